data_sram_axi_bridge: RTL

- Data-side bridge between the MEM stage's SRAM-like request interface (req / addr_ok / data_ok) and an AXI3 master port.
- Sits directly downstream of the MEM stage and consumes its data_req, data_wr, address, byte enables and write data.
- Returns load data and completion pulses that let MEM finish.
- One outstanding transaction at a time, full-word bus with byte strobes.

---
 rtl/data_bridge_pkg.sv | 19 +
 rtl/data_sram_axi_bridge.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/data_bridge_pkg.sv
// Shared definitions for the data-side SRAM-to-AXI bridge: FSM encoding and
// the fixed AXI single-beat, full-word transfer attributes.
package data_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4
   } bridge_state_e;

   localparam logic [2:0] SIZE_WORD  = 3'b010;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [3:0] LEN_SINGLE = 4'd0;

   localparam int DATA_ID_DEFAULT = 1;

endpackage

// File: rtl/data_sram_axi_bridge.sv
// Bridges the MEM stage's SRAM-like data port (req/addr_ok/data_ok) onto an
// AXI3 master with one outstanding single-beat word transfer at a time.
module data_sram_axi_bridge
   import data_bridge_pkg::*;
#(
   parameter int ID_W    = 4,
   parameter int DATA_ID = DATA_ID_DEFAULT
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            data_req,
   input  logic            data_wr,
   input  logic [3:0]      data_wen,
   input  logic [31:0]     data_addr,
   input  logic [31:0]     data_wdata,
   output logic            data_addr_ok,
   output logic            data_data_ok,
   output logic [31:0]     data_rdata,
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [3:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic            arvalid,
   input  logic            arready,
   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready,
   output logic [ID_W-1:0] awid,
   output logic [31:0]     awaddr,
   output logic [3:0]      awlen,
   output logic [2:0]      awsize,
   output logic [1:0]      awburst,
   output logic            awvalid,
   input  logic            awready,
   output logic [ID_W-1:0] wid,
   output logic [31:0]     wdata,
   output logic [3:0]      wstrb,
   output logic            wlast,
   output logic            wvalid,
   input  logic            wready,
   input  logic [ID_W-1:0] bid,
   input  logic [1:0]      bresp,
   input  logic            bvalid,
   output logic            bready
);

   bridge_state_e state_q, state_d;

   logic        arvalid_q, arvalid_d;
   logic        rready_q,  rready_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q,  wvalid_d;
   logic        bready_q,  bready_d;
   logic        data_ok_q, data_ok_d;
   logic [31:0] rdata_q,   rdata_d;
   logic [31:0] addr_q,    addr_d;
   logic        wr_q,      wr_d;
   logic [3:0]  wen_q,     wen_d;
   logic [31:0] wdata_q,   wdata_d;

   logic accept;
   logic aw_done;
   logic w_done;
   logic resp_hs;

   // Response data, IDs and the sub-word address bits carry no information here.
   logic unused_ok;
   assign unused_ok = ^{rid, rresp, rlast, bid, bresp, data_addr[1:0]};

   assign accept  = (state_q == IDLE) && data_req;
   assign aw_done = !awvalid_q || awready;
   assign w_done  = !wvalid_q || wready;
   assign resp_hs = wr_q ? ((state_q == WR_RESP) && bvalid && bready_q)
                         : ((state_q == RD_DATA) && rvalid && rready_q);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         data_ok_q <= 1'b0;
         rdata_q   <= 32'd0;
         addr_q    <= 32'd0;
         wr_q      <= 1'b0;
         wen_q     <= 4'd0;
         wdata_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         data_ok_q <= data_ok_d;
         rdata_q   <= rdata_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         wen_q     <= wen_d;
         wdata_q   <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (data_req) state_d = data_wr ? WR_REQ : RD_ADDR;
         RD_ADDR: if (arready) state_d = RD_DATA;
         RD_DATA: if (resp_hs) state_d = IDLE;
         WR_REQ:  if (aw_done && w_done) state_d = WR_RESP;
         WR_RESP: if (resp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // AW and W retire independently; B is only opened once both have gone.
   always_comb begin
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      data_ok_d = 1'b0;
      rdata_d   = rdata_q;
      addr_d    = addr_q;
      wr_d      = wr_q;
      wen_d     = wen_q;
      wdata_d   = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d    = {data_addr[31:2], 2'b00};
               wr_d      = data_wr;
               wen_d     = data_wen;
               wdata_d   = data_wdata;
               arvalid_d = !data_wr;
               awvalid_d = data_wr;
               wvalid_d  = data_wr;
            end
         end
         RD_ADDR: begin
            if (arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         RD_DATA: begin
            if (resp_hs) begin
               rdata_d   = rdata;
               rready_d  = 1'b0;
               data_ok_d = 1'b1;
            end
         end
         WR_REQ: begin
            if (awready) awvalid_d = 1'b0;
            if (wready) wvalid_d = 1'b0;
            if (aw_done && w_done) bready_d = 1'b1;
         end
         WR_RESP: begin
            if (resp_hs) begin
               bready_d  = 1'b0;
               data_ok_d = 1'b1;
            end
         end
         default: begin
            data_ok_d = 1'b0;
         end
      endcase
   end

   assign data_addr_ok = accept;
   assign data_data_ok = data_ok_q;
   assign data_rdata   = rdata_q;

   assign arid    = ID_W'(DATA_ID);
   assign araddr  = addr_q;
   assign arlen   = LEN_SINGLE;
   assign arsize  = SIZE_WORD;
   assign arburst = BURST_INCR;
   assign arvalid = arvalid_q;
   assign rready  = rready_q;

   assign awid    = ID_W'(DATA_ID);
   assign awaddr  = addr_q;
   assign awlen   = LEN_SINGLE;
   assign awsize  = SIZE_WORD;
   assign awburst = BURST_INCR;
   assign awvalid = awvalid_q;

   assign wid     = ID_W'(DATA_ID);
   assign wdata   = wdata_q;
   assign wstrb   = wen_q;
   assign wlast   = 1'b1;
   assign wvalid  = wvalid_q;

   assign bready  = bready_q;

endmodule
